// File: rtl/gfx_decode.sv
// rtl/gfx_decode.sv - shader instruction decode stage with two-entry skid buffer (strict checks: GFX_DECODE_STRICT_EN)
module gfx_decode #(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_insn,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [1:0]          out_class,
  output logic [4:0]          out_op,
  output logic                out_load,
  output logic [3:0]          out_rd,
  output logic [3:0]          out_ra,
  output logic [3:0]          out_rb,
  output logic                out_rd_vec,
  output logic                out_ra_vec,
  output logic                out_rb_vec,
  output logic                out_b_imm,
  output logic                out_b_const,
  output logic [31:0]         out_imm,
  output logic                out_illegal
);

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [1:0]          cls;
    logic [4:0]          op;
    logic                load;
    logic [3:0]          rd;
    logic [3:0]          ra;
    logic [3:0]          rb;
    logic                rd_vec;
    logic                ra_vec;
    logic                rb_vec;
    logic                b_imm;
    logic                b_const;
    logic [31:0]         imm;
    logic                illegal;
  } dec_t;

  // Raw fields
  logic [1:0] f_cls;
  logic [4:0] f_op;
  logic       f_rev;
  logic       f_bimm;
  logic       f_consts;
  logic [1:0] f_mode;
  logic       rd_file_v;
  logic       ra_file_v;
  logic       rb_file_v;
  logic [3:0] rd_n;
  logic [3:0] a_n;
  logic [3:0] b_n;
  logic       a_v;
  logic       b_v;
  logic       illegal;

  assign f_cls    = in_insn[1:0];
  assign f_op     = in_insn[6:2];
  assign f_rev    = in_insn[7];
  assign f_bimm   = in_insn[29];
  assign f_consts = in_insn[28];
  assign f_mode   = in_insn[31:30];

  // reg_mode 0 SVS, 1 SSS, 2 VVS, 3 VVV
  assign rd_file_v = f_mode[1];
  assign ra_file_v = (f_mode != 2'd1);
  assign rb_file_v = (f_mode == 2'd3);

  // VGPR numbers lose their reserved bit 3; an immediate B occupies no register
  assign rd_n = rd_file_v ? {1'b0, in_insn[10:8]} : in_insn[11:8];
  assign a_n  = ra_file_v ? {1'b0, in_insn[14:12]} : in_insn[15:12];
  assign a_v  = ra_file_v;
  assign b_n  = f_bimm ? 4'd0 : (rb_file_v ? {1'b0, in_insn[18:16]} : in_insn[19:16]);
  assign b_v  = !f_bimm && rb_file_v;

`ifdef GFX_DECODE_STRICT_EN
  logic op_bad;
  assign op_bad  = (f_op == 5'd4) || (f_op == 5'd6) || (f_op == 5'd8) || (f_op >= 5'd10);
  assign illegal = ((f_cls == 2'd0) && op_bad)
                || ((f_cls == 2'd1) && (in_insn[6:3] != 4'd0))
                || (!f_bimm && (in_insn[27:20] != 8'd0))
                || (!f_bimm && f_consts && rb_file_v)
                || (rd_file_v && in_insn[11])
                || (ra_file_v && in_insn[15])
                || (!f_bimm && rb_file_v && in_insn[19]);
`else
  logic unused_reserved;
  assign unused_reserved = ^in_insn[27:20];
  assign illegal = 1'b0;
`endif

  dec_t dec;
  dec_t main_q;
  dec_t skid_q;
  logic main_valid;
  logic skid_valid;
  logic accept;
  logic drain;

  // Assemble the decoded record, applying the A/B swap last
  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.cls     = f_cls;
    dec.op      = f_op;
    dec.load    = (f_cls == 2'd1) ? in_insn[2] : 1'b0;
    dec.rd      = rd_n;
    dec.rd_vec  = rd_file_v;
    dec.ra      = f_rev ? b_n : a_n;
    dec.ra_vec  = f_rev ? b_v : a_v;
    dec.rb      = f_rev ? a_n : b_n;
    dec.rb_vec  = f_rev ? a_v : b_v;
    dec.b_imm   = f_bimm;
    dec.b_const = !f_bimm && f_consts;
    dec.imm     = {{19{in_insn[28]}}, in_insn[28:16]};
    dec.illegal = illegal;
  end

  assign accept   = in_valid && in_ready;
  assign drain    = main_valid && out_ready;
  assign in_ready = !skid_valid;

  // Main/skid buffer: skid refills main first, otherwise new words go to main when it frees up
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || drain) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid   = main_valid;
  assign out_pc      = main_q.pc;
  assign out_class   = main_q.cls;
  assign out_op      = main_q.op;
  assign out_load    = main_q.load;
  assign out_rd      = main_q.rd;
  assign out_ra      = main_q.ra;
  assign out_rb      = main_q.rb;
  assign out_rd_vec  = main_q.rd_vec;
  assign out_ra_vec  = main_q.ra_vec;
  assign out_rb_vec  = main_q.rb_vec;
  assign out_b_imm   = main_q.b_imm;
  assign out_b_const = main_q.b_const;
  assign out_imm     = main_q.imm;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_gfx_decode.sv
// tb/tb_gfx_decode.sv - table-driven bench for gfx_decode
module tb_gfx_decode;

`ifdef GFX_DECODE_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [1:0]  out_class;
  logic [4:0]  out_op;
  logic        out_load;
  logic [3:0]  out_rd, out_ra, out_rb;
  logic        out_rd_vec, out_ra_vec, out_rb_vec;
  logic        out_b_imm, out_b_const;
  logic [31:0] out_imm;
  logic        out_illegal;

  int errors = 0;
  int checks = 0;

  gfx_decode #(.PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_class(out_class), .out_op(out_op), .out_load(out_load),
    .out_rd(out_rd), .out_ra(out_ra), .out_rb(out_rb),
    .out_rd_vec(out_rd_vec), .out_ra_vec(out_ra_vec), .out_rb_vec(out_rb_vec),
    .out_b_imm(out_b_imm), .out_b_const(out_b_const),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [1:0]  cls;
    logic [4:0]  op;
    logic        load;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  vec;
    logic        bimm;
    logic        bconst;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vt[12];

  function automatic logic [31:0] mk(input logic [1:0] mode, input logic bimm, input logic [12:0] hi,
                                     input logic [3:0] ra, input logic [3:0] rd, input logic rev,
                                     input logic [4:0] op, input logic [1:0] cls);
    return {mode, bimm, hi, ra, rd, rev, op, cls};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] fields();
    return {out_class, out_op, out_load, out_rd, out_ra, out_rb,
            out_rd_vec, out_ra_vec, out_rb_vec, out_b_imm, out_b_const, out_illegal};
  endfunction

  task automatic push(input logic [31:0] insn, input logic [31:0] pc);
    @(negedge clk);
    in_valid = 1'b1;
    in_insn  = insn;
    in_pc    = pc;
  endtask

  int idx;
  int rcv;
  logic [31:0] words[4];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_insn = '0; in_pc = '0; out_ready = 1'b1;

    //                 insn                                          cls op  ld rd  ra  rb  vec    bi bc imm           ill
    vt[0]  = '{mk(2'd1, 1'b0, {1'b0, 8'h00, 4'd3}, 4'd2, 4'd1, 1'b0, 5'd3, 2'd0),  2'd0, 5'd3, 1'b0, 4'd1, 4'd2, 4'd3, 3'b000, 1'b0, 1'b0, 32'h3, 1'b0};
    vt[1]  = '{mk(2'd2, 1'b0, {1'b0, 8'h00, 4'd9}, 4'd5, 4'd4, 1'b1, 5'd3, 2'd0),  2'd0, 5'd3, 1'b0, 4'd4, 4'd9, 4'd5, 3'b101, 1'b0, 1'b0, 32'h9, 1'b0};
    vt[2]  = '{mk(2'd1, 1'b1, 13'h1FFF, 4'd2, 4'd1, 1'b0, 5'd3, 2'd0),             2'd0, 5'd3, 1'b0, 4'd1, 4'd2, 4'd0, 3'b000, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vt[3]  = '{mk(2'd1, 1'b0, {1'b0, 8'h00, 4'd3}, 4'd2, 4'd1, 1'b0, 5'd4, 2'd0),  2'd0, 5'd4, 1'b0, 4'd1, 4'd2, 4'd3, 3'b000, 1'b0, 1'b0, 32'h3, 1'b1};
    vt[4]  = '{mk(2'd3, 1'b0, {1'b1, 8'h00, 4'd3}, 4'd2, 4'd1, 1'b0, 5'd3, 2'd0),  2'd0, 5'd3, 1'b0, 4'd1, 4'd2, 4'd3, 3'b111, 1'b0, 1'b1, 32'hFFFF_F003, 1'b1};
    vt[5]  = '{mk(2'd0, 1'b0, {1'b0, 8'h00, 4'd7}, 4'd3, 4'd2, 1'b0, 5'd1, 2'd1),  2'd1, 5'd1, 1'b1, 4'd2, 4'd3, 4'd7, 3'b010, 1'b0, 1'b0, 32'h7, 1'b0};
    vt[6]  = '{mk(2'd0, 1'b0, {1'b0, 8'h00, 4'd1}, 4'd1, 4'd0, 1'b0, 5'd2, 2'd1),  2'd1, 5'd2, 1'b0, 4'd0, 4'd1, 4'd1, 3'b010, 1'b0, 1'b0, 32'h1, 1'b1};
    vt[7]  = '{mk(2'd3, 1'b0, {1'b0, 8'h00, 4'd11}, 4'd10, 4'd12, 1'b0, 5'd0, 2'd0), 2'd0, 5'd0, 1'b0, 4'd4, 4'd2, 4'd3, 3'b111, 1'b0, 1'b0, 32'hB, 1'b1};
    vt[8]  = '{mk(2'd1, 1'b0, {1'b0, 8'h01, 4'd3}, 4'd2, 4'd1, 1'b0, 5'd3, 2'd0),  2'd0, 5'd3, 1'b0, 4'd1, 4'd2, 4'd3, 3'b000, 1'b0, 1'b0, 32'h13, 1'b1};
    vt[9]  = '{mk(2'd1, 1'b0, {1'b0, 8'h00, 4'd5}, 4'd6, 4'd7, 1'b0, 5'd31, 2'd2), 2'd2, 5'd31, 1'b0, 4'd7, 4'd6, 4'd5, 3'b000, 1'b0, 1'b0, 32'h5, 1'b0};
    vt[10] = '{mk(2'd2, 1'b1, 13'h0005, 4'd5, 4'd3, 1'b1, 5'd1, 2'd0),             2'd0, 5'd1, 1'b0, 4'd3, 4'd0, 4'd5, 3'b101, 1'b1, 1'b0, 32'h5, 1'b0};
    vt[11] = '{mk(2'd1, 1'b0, 13'h0000, 4'd0, 4'd0, 1'b0, 5'd10, 2'd0),            2'd0, 5'd10, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset data", {out_pc, out_imm}, 64'd0);
    check("reset fields", 64'(fields()), 64'd0);

    // Table of single decodes, one-cycle latency each
    for (int i = 0; i < 12; i++) begin
      push(vt[i].insn, 32'h1000 + 32'(i));
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("vec%0d valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d pc", i), 64'(out_pc), 64'h1000 + 64'(i));
      check($sformatf("vec%0d fields", i), 64'(fields()),
            64'({vt[i].cls, vt[i].op, vt[i].load, vt[i].rd, vt[i].ra, vt[i].rb,
                 vt[i].vec, vt[i].bimm, vt[i].bconst, vt[i].ill & STRICT}));
      check($sformatf("vec%0d imm", i), 64'(out_imm), 64'(vt[i].imm));
    end
    @(negedge clk);
    check("drained", 64'(out_valid), 64'd0);

    // Four back-to-back words, out_ready low for the first three cycles
    for (int i = 0; i < 4; i++) words[i] = vt[i].insn;
    idx = 0;
    rcv = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 3);
      in_valid  = (idx < 4);
      in_insn   = words[idx % 4];
      in_pc     = 32'd100 + 32'(idx);
      if (cyc == 2) begin
        check("stream accepts before stall", 64'(idx), 64'd2);
        check("stream in_ready stall", 64'(in_ready), 64'd0);
        check("stream hold pc", 64'(out_pc), 64'd100);
      end
      if (out_valid && out_ready) begin
        check($sformatf("stream order %0d", rcv), 64'(out_pc), 64'd100 + 64'(rcv));
        check($sformatf("stream op %0d", rcv), 64'(out_op), 64'(vt[rcv].op));
        rcv++;
      end
      @(posedge clk);
      if (in_valid && in_ready) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("stream accepted", 64'(idx), 64'd4);
    check("stream received", 64'(rcv), 64'd4);
    check("stream empty", 64'(out_valid), 64'd0);

    // Fill skid then flush (with an input offered in the flush cycle), then the same with reset
    for (int pass = 0; pass < 2; pass++) begin
      out_ready = 1'b0;
      push(vt[0].insn, 32'd200);
      push(vt[1].insn, 32'd201);
      @(negedge clk);
      check($sformatf("pass%0d skid full", pass), 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      in_insn  = vt[2].insn;
      in_pc    = 32'd202;
      if (pass == 0) flush = 1'b1; else rst = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      rst = 1'b0;
      in_valid = 1'b0;
      check($sformatf("pass%0d out_valid", pass), 64'(out_valid), 64'd0);
      check($sformatf("pass%0d in_ready", pass), 64'(in_ready), 64'd1);
      if (pass == 1) check("rst data zero", {out_pc, out_imm}, 64'd0);
      out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("pass%0d dropped", pass), 64'(out_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
